pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16; maximum MEMWAIT cycles before the error flag sets.
REQ-002 Parameter: CNT_W, default 32; width of the stall and flush counters.
REQ-003 Port: clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_i  in  1  asynchronous, active-low reset.
REQ-005 Port: start_i  in  1  high = CPU running.
REQ-006 Port: id_rs1_i  in  5  rs1 index of the instruction in ID.
REQ-007 Port: id_rs2_i  in  5  rs2 index of the instruction in ID.
REQ-008 Port: id_rs2_valid_i  in  1  instruction in ID reads rs2.
REQ-009 Port: ex_memread_i  in  1  instruction in EX is a load.
REQ-010 Port: ex_rd_i  in  5  destination register of the instruction in EX.
REQ-011 Port: id_branch_taken_i  in  1  branch in ID resolved taken.
REQ-012 Port: mem_req_i  in  1  MEM stage holds a load or store.
REQ-013 Port: mem_ack_i  in  1  data memory has completed the access this cycle.
REQ-014 Port: pc_write_o  out  1  PC update enable.
REQ-015 Port: ifid_write_o  out  1  IF/ID register write enable.
REQ-016 Port: ifid_flush_o  out  1  clears IF/ID to a NOP.
REQ-017 Port: idex_bubble_o  out  1  zeroes the ID/EX control fields.
REQ-018 Port: pipe_freeze_o  out  1  holds ID/EX, EX/MEM and MEM/WB.
REQ-019 Port: stall_cnt_o  out  CNT_W  count of load-use stall cycles.
REQ-020 Port: flush_cnt_o  out  CNT_W  count of flush cycles.
REQ-021 Port: mem_err_o  out  1  sticky memory-timeout error.
REQ-022 Port: state_o  out  2  current state: IDLE=0, RUN=1, MEMWAIT=2.

Function
REQ-023 The FSM SHALL have the states IDLE, RUN and MEMWAIT; encoding 3 is unreachable and SHALL recover to IDLE.
REQ-024 In IDLE, pc_write_o and ifid_write_o SHALL be 0 and pipe_freeze_o SHALL be 1; the FSM SHALL move to RUN on the first edge where start_i=1.
REQ-025 In RUN or MEMWAIT, start_i=0 SHALL return the FSM to IDLE on the next edge, taking priority over all other transitions.
REQ-026 In RUN, the FSM SHALL move to MEMWAIT when mem_req_i=1 and mem_ack_i=0, and SHALL stay in RUN when the two are sampled together high.
REQ-027 In MEMWAIT, mem_ack_i=1 SHALL return the FSM to RUN on the next edge.
REQ-028 In MEMWAIT, the outputs SHALL be pc_write_o=0, ifid_write_o=0 and pipe_freeze_o=1, with ifid_flush_o=0 and idex_bubble_o=0.
REQ-029 In MEMWAIT, a wait counter SHALL increment each cycle; reaching MEM_TIMEOUT SHALL set mem_err_o and force the FSM to RUN.
REQ-030 mem_err_o SHALL clear only on reset.
REQ-031 A load-use hazard SHALL be detected as: ex_memread_i=1, ex_rd_i≠0, and (ex_rd_i==id_rs1_i or (id_rs2_valid_i and ex_rd_i==id_rs2_i)).
REQ-032 On a load-use hazard in RUN, the block SHALL drive pc_write_o=0, ifid_write_o=0 and idex_bubble_o=1, combinationally in the same cycle.
REQ-033 On a taken branch in RUN with no load-use hazard, the block SHALL drive ifid_flush_o=1 with pc_write_o=1.
REQ-034 On a load-use hazard and a taken branch together, the stall SHALL win and ifid_flush_o SHALL be 0.
REQ-035 Output priority SHALL be: IDLE > MEMWAIT > load-use stall > flush > normal.
REQ-036 In RUN with no hazard, pc_write_o=1, ifid_write_o=1 and every other control output SHALL be 0.
REQ-037 stall_cnt_o SHALL increment on each edge where idex_bubble_o=1.
REQ-038 flush_cnt_o SHALL increment on each edge where ifid_flush_o=1.
REQ-039 Both counters SHALL saturate at 2^CNT_W−1 and never wrap.
REQ-040 Counters SHALL hold their values in IDLE and MEMWAIT.

Reset
REQ-041 rst_i=0 SHALL force, asynchronously: state IDLE, stall_cnt_o=0, flush_cnt_o=0, wait counter=0, mem_err_o=0.
REQ-042 While rst_i=0, the outputs SHALL be pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=0, pipe_freeze_o=1.
REQ-043 Reset asserted mid-MEMWAIT SHALL discard the wait count; after release the block SHALL pass through IDLE.

Verification
REQ-044 Reset released, start_i=1 at cycle 2 -> state_o=1 from cycle 3 and pc_write_o=1.
REQ-045 ex_memread_i=1, ex_rd_i=5, id_rs1_i=5 for one cycle -> idex_bubble_o=1 and pc_write_o=0 that cycle, stall_cnt_o=1 after the edge; the same stimulus with ex_rd_i=0 -> no stall.
REQ-046 id_branch_taken_i=1 for 3 cycles -> flush_cnt_o=3; a branch coinciding with a load-use hazard -> ifid_flush_o=0, stall_cnt_o +1, flush_cnt_o unchanged.
REQ-047 mem_req_i=1, mem_ack_i=0 for 4 cycles, then ack -> state_o=2 for 4 cycles, pipe_freeze_o=1, counters held, then RUN.
REQ-048 mem_ack_i held at 0 with MEM_TIMEOUT=16 -> mem_err_o=1 after 16 MEMWAIT cycles, state_o=1, mem_err_o still 1 until reset.
REQ-049 Preload stall_cnt_o near 2^CNT_W−1 with CNT_W=4, apply 20 stalls -> stall_cnt_o=15, no wrap.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// memory-wait freeze for a classic 5-stage pipeline, plus stall/flush
// statistics and a sticky memory-timeout error flag.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs2_valid_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             id_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             mem_err_o,
    output logic [1:0]       state_o
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    // Wait count value on the last permitted MEMWAIT cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_MEMWAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               mem_err_q, mem_err_d;
    logic               err_set_c;
    logic               load_use_c;

    // Load-use hazard: EX holds a load whose (non-x0) destination feeds ID.
    always_comb begin
        load_use_c = 1'b0;
        if (ex_memread_i && (ex_rd_i != 5'd0)) begin
            load_use_c = (ex_rd_i == id_rs1_i) ||
                         (id_rs2_valid_i && (ex_rd_i == id_rs2_i));
        end
    end

    // Next-state logic and memory-wait timeout tracking.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        err_set_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end else if (mem_req_i && !mem_ack_i) begin
                    state_d = S_MEMWAIT;
                end
            end
            S_MEMWAIT: begin
                if (!start_i) begin
                    state_d = S_IDLE;
                end else if (mem_ack_i) begin
                    state_d = S_RUN;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_RUN;
                    err_set_c = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pipeline control outputs, priority IDLE > MEMWAIT > stall > flush > normal.
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_freeze_o = 1'b1;
        if (state_q == S_RUN) begin
            pipe_freeze_o = 1'b0;
            if (load_use_c) begin
                idex_bubble_o = 1'b1;
            end else if (id_branch_taken_i) begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
            end
        end
    end

    // Saturating statistics counters and sticky error.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mem_err_d   = mem_err_q | err_set_c;
        if (idex_bubble_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign mem_err_o   = mem_err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed stimulus, cycle-by-cycle compare
// against a behavioural model, plus literal checkpoints.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 16;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
    logic       id_rs2_valid_i, ex_memread_i, id_branch_taken_i;
    logic       mem_req_i, mem_ack_i;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_err;
    logic [31:0] stall_cnt, flush_cnt;
    logic [1:0]  state;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_pipe_freeze, s_mem_err;
    logic [3:0]  s_stall_cnt, s_flush_cnt;
    logic [1:0]  s_state;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int     m_mode;   // 0 idle, 1 run, 2 waiting on memory
    int     m_wait;
    bit     m_err;
    longint m_stall, m_flush;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rs2_valid_i(id_rs2_valid_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
        .id_branch_taken_i(id_branch_taken_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
        .idex_bubble_o(idex_bubble), .pipe_freeze_o(pipe_freeze),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
        .mem_err_o(mem_err), .state_o(state)
    );

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(4)) dut_small (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rs2_valid_i(id_rs2_valid_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
        .id_branch_taken_i(id_branch_taken_i),
        .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush),
        .idex_bubble_o(s_idex_bubble), .pipe_freeze_o(s_pipe_freeze),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt),
        .mem_err_o(s_mem_err), .state_o(s_state)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hz();
        return ex_memread_i && (ex_rd_i != 5'd0) &&
               ((ex_rd_i == id_rs1_i) || (id_rs2_valid_i && (ex_rd_i == id_rs2_i)));
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    // Compare both instances against the model for the current cycle.
    task automatic compare_all();
        bit run, e_pc, e_ifw, e_fl, e_bub, e_frz;
        run   = rst_i && (m_mode == 1);
        e_bub = run && hz();
        e_fl  = run && !hz() && id_branch_taken_i;
        e_pc  = run && !hz();
        e_ifw = run && !hz();
        e_frz = !run;
        check("pc_write",    64'(pc_write),    64'(e_pc));
        check("ifid_write",  64'(ifid_write),  64'(e_ifw));
        check("ifid_flush",  64'(ifid_flush),  64'(e_fl));
        check("idex_bubble", 64'(idex_bubble), 64'(e_bub));
        check("pipe_freeze", 64'(pipe_freeze), 64'(e_frz));
        check("state",       64'(state),       64'(m_mode));
        check("mem_err",     64'(mem_err),     64'(m_err));
        check("stall_cnt",   64'(stall_cnt),   64'(sat(m_stall, 32)));
        check("flush_cnt",   64'(flush_cnt),   64'(sat(m_flush, 32)));
        check("s_state",     64'(s_state),     64'(m_mode));
        check("s_bubble",    64'(s_idex_bubble), 64'(e_bub));
        check("s_stall_cnt", 64'(s_stall_cnt), 64'(sat(m_stall, 4)));
        check("s_flush_cnt", 64'(s_flush_cnt), 64'(sat(m_flush, 4)));
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_update();
        bit run;
        if (!rst_i) begin
            model_reset();
            return;
        end
        run = (m_mode == 1);
        if (run && hz()) m_stall++;
        else if (run && id_branch_taken_i) m_flush++;
        case (m_mode)
            0: if (start_i) m_mode = 1;
            1: begin
                if (!start_i) m_mode = 0;
                else if (mem_req_i && !mem_ack_i) begin
                    m_mode = 2;
                    m_wait = 0;
                end
            end
            default: begin
                m_wait++;
                if (!start_i) m_mode = 0;
                else if (mem_ack_i) m_mode = 1;
                else if (m_wait >= TMO) begin
                    m_err  = 1;
                    m_mode = 1;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(negedge clk_i);
        compare_all();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic clear_hazards();
        ex_memread_i = 0; ex_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
        id_rs2_valid_i = 0; id_branch_taken_i = 0;
    endtask

    initial begin
        longint st0, fl0;
        rst_i = 0; start_i = 0; mem_req_i = 0; mem_ack_i = 0;
        clear_hazards();
        model_reset();

        // Held in reset
        repeat (3) tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_freeze", 64'(pipe_freeze), 64'd1);
        check("rst_pc", 64'(pc_write), 64'd0);

        // Release and start
        rst_i = 1;
        tick();
        start_i = 1;
        tick();
        check("start_state", 64'(state), 64'd1);
        check("start_pc", 64'(pc_write), 64'd1);

        // Load-use on rs1
        ex_memread_i = 1; ex_rd_i = 5; id_rs1_i = 5; #1;
        check("lu_bubble", 64'(idex_bubble), 64'd1);
        check("lu_pc", 64'(pc_write), 64'd0);
        tick();
        check("lu_stall_cnt", 64'(stall_cnt), 64'd1);
        // x0 destination never stalls
        ex_rd_i = 0; id_rs1_i = 0; #1;
        check("x0_bubble", 64'(idex_bubble), 64'd0);
        check("x0_pc", 64'(pc_write), 64'd1);
        tick();
        check("x0_stall_cnt", 64'(stall_cnt), 64'd1);
        // rs2 path, valid then not valid
        ex_rd_i = 7; id_rs1_i = 3; id_rs2_i = 7; id_rs2_valid_i = 1;
        tick();
        id_rs2_valid_i = 0;
        tick();
        check("rs2_stall_cnt", 64'(stall_cnt), 64'd2);
        clear_hazards();

        // Three taken branches
        id_branch_taken_i = 1;
        repeat (3) tick();
        id_branch_taken_i = 0; #1;
        check("br_flush_cnt", 64'(flush_cnt), 64'd3);

        // Branch plus load-use: stall wins
        id_branch_taken_i = 1; ex_memread_i = 1; ex_rd_i = 5; id_rs1_i = 5; #1;
        check("both_flush", 64'(ifid_flush), 64'd0);
        check("both_bubble", 64'(idex_bubble), 64'd1);
        tick();
        check("both_stall_cnt", 64'(stall_cnt), 64'd3);
        check("both_flush_cnt", 64'(flush_cnt), 64'd3);
        clear_hazards();
        tick();

        // Memory wait with late ack; hazards ignored while waiting
        mem_req_i = 1; mem_ack_i = 0;
        tick();
        check("mw_state", 64'(state), 64'd2);
        id_branch_taken_i = 1; ex_memread_i = 1; ex_rd_i = 5; id_rs1_i = 5; #1;
        check("mw_freeze", 64'(pipe_freeze), 64'd1);
        check("mw_flush", 64'(ifid_flush), 64'd0);
        tick();
        tick();
        mem_ack_i = 1; #1;
        check("mw_state4", 64'(state), 64'd2);
        tick();
        check("mw_back_run", 64'(state), 64'd1);
        check("mw_stall_held", 64'(stall_cnt), 64'd3);
        check("mw_flush_held", 64'(flush_cnt), 64'd3);
        clear_hazards();
        // req and ack together stay in RUN
        tick();
        check("reqack_run", 64'(state), 64'd1);
        mem_ack_i = 0;

        // Timeout
        tick();
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            check("tmo_wait", 64'(state), 64'd2);
        end
        tick();
        mem_req_i = 0;
        check("tmo_state", 64'(state), 64'd1);
        check("tmo_err", 64'(mem_err), 64'd1);
        repeat (3) tick();
        check("err_sticky", 64'(mem_err), 64'd1);

        // Reset in the middle of a memory wait
        mem_req_i = 1;
        repeat (3) tick();
        #1 rst_i = 0;
        model_reset();
        #1;
        check("arst_state", 64'(state), 64'd0);
        check("arst_err", 64'(mem_err), 64'd0);
        check("arst_stall", 64'(stall_cnt), 64'd0);
        check("arst_freeze", 64'(pipe_freeze), 64'd1);
        repeat (2) tick();
        rst_i = 1; #1;
        check("post_rst_idle", 64'(state), 64'd0);
        tick();
        check("post_rst_run", 64'(state), 64'd1);
        tick();
        for (int i = 0; i < TMO - 1; i++) tick();
        check("tmo2_no_err", 64'(mem_err), 64'd0);
        tick();
        mem_req_i = 0;
        check("tmo2_err", 64'(mem_err), 64'd1);

        // Stall counter saturation on the narrow instance
        st0 = m_stall; fl0 = m_flush;
        ex_memread_i = 1; ex_rd_i = 9; id_rs1_i = 9;
        repeat (20) tick();
        check("sat_small", 64'(s_stall_cnt), 64'd15);
        check("sat_wide", 64'(stall_cnt), 64'(st0 + 20));
        check("sat_flush", 64'(s_flush_cnt), 64'(fl0));

        // Stop: back to IDLE, hazard ignored
        start_i = 0;
        tick();
        check("stop_state", 64'(state), 64'd0);
        check("stop_bubble", 64'(idex_bubble), 64'd0);
        tick();
        check("stop_sat_held", 64'(s_stall_cnt), 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
